// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, opcodes,
// ALU functions, datapath select codes and fault causes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b110,
        S_ERR  = 3'b111
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_IMEM    = 2'b01,
        ERR_DMEM    = 2'b10,
        ERR_ILLEGAL = 2'b11
    } err_code_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLTI = 6'b011100;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_BNE  = 6'b110001;
    localparam logic [5:0] OP_BLTZ = 6'b110010;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLTI,
            OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ, OP_J, OP_JR, OP_JAL,
            OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_rtype(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic uses_imm(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ORI, OP_SLTI, OP_LW, OP_SW: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        case (op)
            OP_BEQ, OP_BNE, OP_BLTZ: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: return ALU_SUB;
            OP_SLL:                          return ALU_SLL;
            OP_OR, OP_ORI:                   return ALU_OR;
            OP_AND:                          return ALU_AND;
            OP_SLTI:                         return ALU_SLT;
            default:                         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: decode inputs, memory handshakes, every
// datapath enable and the debug/status outputs.
interface mc_if #(parameter int CNT_W = 32);
    logic [5:0]       Opcode;
    logic             zero;
    logic             sign;
    logic             imem_ready;
    logic             dmem_ready;
    logic             PCWre;
    logic             IRWre;
    logic             RegWre;
    logic             ALUSrcA;
    logic             ALUSrcB;
    logic             ExtSel;
    logic             WrRegDSrc;
    logic             DBDataSrc;
    logic             nRD;
    logic             nWR;
    logic [1:0]       RegDst;
    logic [1:0]       PCSrc;
    logic [2:0]       ALUOp;
    logic             imem_req;
    logic [2:0]       state;
    logic             halted;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] retired;

    modport master (
        input  Opcode, zero, sign, imem_ready, dmem_ready,
        output PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc,
               DBDataSrc, nRD, nWR, RegDst, PCSrc, ALUOp, imem_req, state,
               halted, err, err_code, retired
    );

    modport slave (
        output Opcode, zero, sign, imem_ready, dmem_ready,
        input  PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc,
               DBDataSrc, nRD, nWR, RegDst, PCSrc, ALUOp, imem_req, state,
               halted, err, err_code, retired
    );
endinterface

// File: rtl/mc_wait_watchdog.sv
// Consecutive-wait counter for IF/MEM; saturates at WAIT_MAX and flags expiry.
module mc_wait_watchdog #(
    parameter int WAIT_MAX = 8
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(WAIT_MAX));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer with memory wait handshakes,
// wait watchdog, illegal-opcode trap, HALT and retired-instruction counter.
//
//   state | meaning
//   IF    | fetch: imem_req, IRWre when imem_ready
//   ID    | decode; jumps complete here
//   EXE   | ALU step; branches complete here
//   MEM   | data access held until dmem_ready; SW completes here
//   WB    | register write-back and PC+4
//   HALT  | stopped until Reset
//   ERR   | fault trapped (err/err_code) until Reset
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int HAS_WAIT = 1,
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 32
) (
    input  logic CLK,
    input  logic Reset,
    mc_if.master bus
);
    state_t           state_q, state_d;
    err_code_t        err_code_q, err_code_d;
    logic             err_q;
    logic [CNT_W-1:0] retired_q;
    logic             imem_rdy, dmem_rdy;
    logic             wd_inc, wd_clr, wd_expired, fault;
    logic             taken, alu_phase;
    logic [5:0]       op;

    assign op       = bus.Opcode;
    assign imem_rdy = (HAS_WAIT != 0) ? bus.imem_ready : 1'b1;
    assign dmem_rdy = (HAS_WAIT != 0) ? bus.dmem_ready : 1'b1;

    // Ready wins over expiry: the counter only advances while not ready.
    assign wd_inc = ((state_q == S_IF) && !imem_rdy) || ((state_q == S_MEM) && !dmem_rdy);
    assign wd_clr = (state_d != state_q);
    assign fault  = wd_inc && wd_expired;

    assign taken = ((op == OP_BEQ) && bus.zero) || ((op == OP_BNE) && !bus.zero) ||
                   ((op == OP_BLTZ) && bus.sign);

    mc_wait_watchdog #(.WAIT_MAX(WAIT_MAX)) u_watchdog (
        .CLK     (CLK),
        .Reset   (Reset),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IF;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            retired_q  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d == S_ERR) && (state_q != S_ERR)) begin
                err_q      <= 1'b1;
                err_code_q <= err_code_d;
            end
            if (bus.PCWre) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = ERR_NONE;
        case (state_q)
            S_IF: begin
                if (imem_rdy) begin
                    state_d = S_ID;
                end else if (wd_expired) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_IMEM;
                end
            end
            S_ID: begin
                if (op == OP_J || op == OP_JR || op == OP_JAL) begin
                    state_d = S_IF;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_legal(op)) begin
                    state_d = S_EXE;
                end else begin
                    state_d    = S_ERR;
                    err_code_d = ERR_ILLEGAL;
                end
            end
            S_EXE: begin
                if (is_branch(op))                    state_d = S_IF;
                else if (op == OP_LW || op == OP_SW)  state_d = S_MEM;
                else                                  state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_rdy) begin
                    state_d = (op == OP_SW) ? S_IF : S_WB;
                end else if (wd_expired) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_DMEM;
                end
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IF;
        endcase
    end

    assign alu_phase = (state_q == S_EXE) || (state_q == S_MEM) || (state_q == S_WB);

    // All enables are gated by Reset so a reset mid-access drops strobes at once.
    always_comb begin
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.RegWre    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.ExtSel    = 1'b0;
        bus.WrRegDSrc = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.nRD       = 1'b1;
        bus.nWR       = 1'b1;
        bus.RegDst    = RD_RA;
        bus.PCSrc     = PC_SEQ;
        bus.ALUOp     = ALU_ADD;
        bus.imem_req  = 1'b0;
        if (Reset) begin
            if (alu_phase) begin
                bus.ALUSrcA = (op == OP_SLL);
                bus.ALUSrcB = uses_imm(op);
                bus.ExtSel  = (op != OP_ORI);
                bus.ALUOp   = alu_op_of(op);
            end
            case (state_q)
                S_IF: begin
                    bus.imem_req = !fault;
                    bus.IRWre    = imem_rdy;
                end
                S_ID: begin
                    case (op)
                        OP_J: begin
                            bus.PCWre = 1'b1;
                            bus.PCSrc = PC_JUMP;
                        end
                        OP_JR: begin
                            bus.PCWre = 1'b1;
                            bus.PCSrc = PC_RS;
                        end
                        OP_JAL: begin
                            bus.PCWre     = 1'b1;
                            bus.PCSrc     = PC_JUMP;
                            bus.RegWre    = 1'b1;
                            bus.RegDst    = RD_RA;
                            bus.WrRegDSrc = 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_EXE: begin
                    if (is_branch(op)) begin
                        bus.PCWre = 1'b1;
                        bus.PCSrc = taken ? PC_BRANCH : PC_SEQ;
                    end
                end
                S_MEM: begin
                    bus.nRD   = !((op == OP_LW) && !fault);
                    bus.nWR   = !((op == OP_SW) && !fault);
                    bus.PCWre = (op == OP_SW) && dmem_rdy;
                end
                S_WB: begin
                    bus.RegWre    = 1'b1;
                    bus.PCWre     = 1'b1;
                    bus.WrRegDSrc = 1'b1;
                    bus.DBDataSrc = (op == OP_LW);
                    bus.RegDst    = is_rtype(op) ? RD_RD : RD_RT;
                end
                default: ;
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.halted   = (state_q == S_HALT);
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
    assign bus.retired  = retired_q;
endmodule
